// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
// Optional lap-hold feature is enabled with the STOPWATCH_LAP_HOLD_EN macro.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] SEC_UNITS_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
  localparam logic [3:0] MIN_UNITS_MAX = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX  = 4'd5;

  // Decimal points on the display stage are active-low.
  localparam logic DOT_ON  = 1'b0;
  localparam logic DOT_OFF = 1'b1;

endpackage

// File: rtl/stopwatch_bcd_digit_counter.sv
// Single BCD digit that counts 0..MAX and raises carry when it rolls over.
// Chained four times to form the MM:SS cascade.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = SEC_UNITS_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] r_q;

  // Digit register: clear wins over increment, and MAX rolls back to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= 4'd0;
    end else if (clr) begin
      r_q <= 4'd0;
    end else if (inc) begin
      r_q <= (r_q == MAX) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q     = r_q;
  assign carry = inc && (r_q == MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS stopwatch top: run/pause/clear FSM, 1 Hz prescaler, BCD digit cascade
// and blinking separator dot for the downstream 4-digit multiplexed display.
// Define STOPWATCH_LAP_HOLD_EN to add the lap input and display hold register.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] hexa3,
  output logic [3:0] hexa2,
  output logic [3:0] hexa1,
  output logic [3:0] hexa0,
  output logic [3:0] puntos4,
  output logic       running,
  output logic       ovf
`ifdef STOPWATCH_LAP_HOLD_EN
  ,
  input  logic       lap
`endif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

  state_t          r_state;
  state_t          w_nextState;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_nextPresc;
  logic            w_tick;
  logic            r_dot;
  logic            r_running;
  logic            r_ovf;

  logic [3:0]      w_q0, w_q1, w_q2, w_q3;
  logic            w_carry0, w_carry1, w_carry2, w_carry3;
  logic [15:0]     w_liveDigits;

  // State register for the run/pause/idle controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: clear overrides start_stop, which toggles between RUN and PAUSE.
  always_comb begin
    w_nextState = r_state;
    if (clear) begin
      w_nextState = IDLE;
    end else if (start_stop) begin
      case (r_state)
        IDLE:    w_nextState = RUN;
        RUN:     w_nextState = PAUSE;
        PAUSE:   w_nextState = RUN;
        default: w_nextState = IDLE;
      endcase
    end
  end

  assign w_tick = (r_state == RUN) && (r_presc == PRESC_LAST);

  // Prescaler next value: advances only in RUN, holds in PAUSE so resume keeps the partial second.
  always_comb begin
    w_nextPresc = r_presc;
    if (clear) begin
      w_nextPresc = '0;
    end else if ((r_state == IDLE) && (w_nextState == RUN)) begin
      w_nextPresc = '0;
    end else if (r_state == RUN) begin
      w_nextPresc = w_tick ? '0 : r_presc + PW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_nextPresc;
    end
  end

  bcd_digit_counter #(.MAX(SEC_UNITS_MAX)) u_secUnits (
    .clk(clk), .reset(reset), .clr(clear), .inc(w_tick),
    .q(w_q0), .carry(w_carry0)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_secTens (
    .clk(clk), .reset(reset), .clr(clear), .inc(w_carry0),
    .q(w_q1), .carry(w_carry1)
  );

  bcd_digit_counter #(.MAX(MIN_UNITS_MAX)) u_minUnits (
    .clk(clk), .reset(reset), .clr(clear), .inc(w_carry1),
    .q(w_q2), .carry(w_carry2)
  );

  bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_minTens (
    .clk(clk), .reset(reset), .clr(clear), .inc(w_carry2),
    .q(w_q3), .carry(w_carry3)
  );

  assign w_liveDigits = {w_q3, w_q2, w_q1, w_q0};

  // Status outputs are computed from next-cycle values so they line up with the registered state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dot     <= DOT_ON;
      r_running <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_dot     <= ((w_nextState == RUN) && (w_nextPresc >= PRESC_HALF)) ? DOT_OFF : DOT_ON;
      r_running <= (w_nextState == RUN);
      r_ovf     <= w_carry3 && !clear;
    end
  end

  assign puntos4 = {1'b1, r_dot, 2'b11};
  assign running = r_running;
  assign ovf     = r_ovf;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        r_holdActive;
  logic [15:0] r_holdDigits;

  // Lap hold: first lap in RUN freezes the pre-edge digits, the next lap releases them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_holdActive <= 1'b0;
      r_holdDigits <= 16'd0;
    end else if (clear) begin
      r_holdActive <= 1'b0;
    end else if (lap && (r_state == RUN)) begin
      r_holdActive <= !r_holdActive;
      if (!r_holdActive) begin
        r_holdDigits <= w_liveDigits;
      end
    end
  end

  assign {hexa3, hexa2, hexa1, hexa0} = r_holdActive ? r_holdDigits : w_liveDigits;
`else
  assign {hexa3, hexa2, hexa1, hexa0} = w_liveDigits;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard testbench for stopwatch_bcd with TICK_DIV = 4.
// The reference model tracks elapsed whole seconds and the phase inside the
// current second; expected outputs are derived from those with plain arithmetic.
module tb_stopwatch_bcd;

  localparam int TICK_DIV = 4;

  typedef struct packed {
    logic [3:0] h3;
    logic [3:0] h2;
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] dots;
    logic       run;
    logic       ovf;
  } outVec_t;

  typedef enum int {M_IDLE, M_COUNTING, M_HALTED} modelMode_t;

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP_ENABLED = 1'b1;
`else
  localparam bit LAP_ENABLED = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       start_stop;
  logic       clear;
  logic [3:0] hexa3, hexa2, hexa1, hexa0;
  logic [3:0] puntos4;
  logic       running;
  logic       ovf;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic       lapIn;
`endif

  int checkCount = 0;
  int failCount  = 0;
  int dutOvfCount = 0;
  int modelOvfCount = 0;

  outVec_t expQ[$];

  modelMode_t mMode = M_IDLE;
  int mPhase   = 0;
  int mSeconds = 0;
  bit mHold    = 1'b0;
  int mHeld    = 0;

  stopwatch_bcd #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk),
    .reset(reset),
    .start_stop(start_stop),
    .clear(clear),
    .hexa3(hexa3),
    .hexa2(hexa2),
    .hexa1(hexa1),
    .hexa0(hexa0),
    .puntos4(puntos4),
    .running(running),
    .ovf(ovf)
`ifdef STOPWATCH_LAP_HOLD_EN
    ,
    .lap(lapIn)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outVec_t sampleDut();
    outVec_t v;
    v.h3 = hexa3;
    v.h2 = hexa2;
    v.h1 = hexa1;
    v.h0 = hexa0;
    v.dots = puntos4;
    v.run = running;
    v.ovf = ovf;
    return v;
  endfunction

  function automatic outVec_t resetVec();
    outVec_t v;
    v = '0;
    v.dots = 4'b1011;
    return v;
  endfunction

  task automatic checkOutput(input string name, input outVec_t got, input outVec_t want);
    checkCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h%h:%h%h dots=%b run=%b ovf=%b, expected %h%h:%h%h dots=%b run=%b ovf=%b",
               name, $time, got.h3, got.h2, got.h1, got.h0, got.dots, got.run, got.ovf,
               want.h3, want.h2, want.h1, want.h0, want.dots, want.run, want.ovf);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    checkCount++;
    if (got != want) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model by one edge and queue its outputs.
  task automatic applyStimulus(input bit ss, input bit clr, input bit lp);
    bit      tickNow;
    bit      ovfNow;
    int      shown;
    outVec_t want;
    @(negedge clk);
    #1;
    start_stop = ss;
    clear      = clr;
`ifdef STOPWATCH_LAP_HOLD_EN
    lapIn      = lp;
`endif
    tickNow = (mMode == M_COUNTING) && (mPhase == TICK_DIV - 1);
    ovfNow  = !clr && tickNow && (mSeconds == 3599);
    if (ovfNow) modelOvfCount++;
    if (clr) begin
      mMode    = M_IDLE;
      mPhase   = 0;
      mSeconds = 0;
      mHold    = 1'b0;
    end else begin
      if (LAP_ENABLED && lp && (mMode == M_COUNTING)) begin
        if (mHold) begin
          mHold = 1'b0;
        end else begin
          mHold = 1'b1;
          mHeld = mSeconds;
        end
      end
      if (tickNow) mSeconds = (mSeconds + 1) % 3600;
      if (mMode == M_COUNTING) mPhase = (mPhase + 1) % TICK_DIV;
      if (ss) begin
        case (mMode)
          M_IDLE:     begin mMode = M_COUNTING; mPhase = 0; end
          M_COUNTING: mMode = M_HALTED;
          default:    mMode = M_COUNTING;
        endcase
      end
    end
    shown     = mHold ? mHeld : mSeconds;
    want.h3   = 4'(shown / 600);
    want.h2   = 4'((shown / 60) % 10);
    want.h1   = 4'((shown % 60) / 10);
    want.h0   = 4'(shown % 10);
    want.dots = {1'b1, ((mMode == M_COUNTING) && (mPhase >= TICK_DIV / 2)), 2'b11};
    want.run  = (mMode == M_COUNTING);
    want.ovf  = ovfNow;
    expQ.push_back(want);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between clock edges, checked before the next rising edge.
  task automatic resetMidCount();
    @(negedge clk);
    #2;
    start_stop = 1'b0;
    clear      = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
    lapIn      = 1'b0;
`endif
    reset = 1'b1;
    #1;
    checkOutput("asyncReset", sampleDut(), resetVec());
    mMode    = M_IDLE;
    mPhase   = 0;
    mSeconds = 0;
    mHold    = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every falling edge compares the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    outVec_t want;
    if (!reset && (expQ.size() > 0)) begin
      want = expQ.pop_front();
      checkOutput("scoreboard", sampleDut(), want);
      if (ovf) dutOvfCount++;
    end
  end

  initial begin
    reset      = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
    lapIn      = 1'b0;
`endif
    @(negedge clk);
    #1;
    checkOutput("resetState", sampleDut(), resetVec());
    reset = 1'b0;

    $display("[TB] count to 00:10");
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(40);

    $display("[TB] pause and resume");
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(13);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(20);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(6);

    $display("[TB] clear beats start_stop");
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(4);

    $display("[TB] reset mid-count");
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(9);
    resetMidCount();
    idleCycles(3);

    $display("[TB] lap hold");
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(19);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(8);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(6);

    $display("[TB] randomized pulses");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(19) == 0), ($urandom_range(149) == 0), ($urandom_range(14) == 0));
    end

    $display("[TB] wrap 59:59 -> 00:00");
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(3600 * TICK_DIV + 12);

    @(negedge clk);
    #2;
    checkValue("queueDrained", expQ.size(), 0);
    checkValue("ovfPulses", dutOvfCount, modelOvfCount);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
